// File: rtl/aes_v3_word.sv
// Word-wide AES round-step unit for the V3 scalar AES instruction family.
// Processes all four bytes of a 32-bit column per instruction:
//   mix=0 : SubWord (forward or inverse S-box on every byte) ^ rs2,
//           SBOXES bytes per cycle through shared aes_sbox instances.
//   mix=1 : MixColumns / InvMixColumns of rs1 ^ rs2, single cycle.
// Parameters:
//   SBOXES      : shared S-box instances, legal values 1, 2, 4.
//   GATE_OUTPUT : 1 forces rd to 0 whenever ready is low.
// Ports:
//   g_clk, g_resetn : clock (rising edge), asynchronous active-low reset.
//   valid           : request valid, held until ready.
//   dec             : 0 = forward (encrypt), 1 = inverse (decrypt).
//   mix             : 0 = SubWord, 1 = (Inv)MixColumns.
//   rs1, rs2        : source column and XOR operand.
//   rd              : result, valid while ready is high.
//   ready           : one-cycle completion pulse.
//   busy            : high while an accepted operation is in flight.

// Combinational AES S-box (forward or inverse), computed via GF(2^8) inversion.
// Ports: data = input byte, inv = 1 selects the inverse S-box, result = output byte.
module aes_sbox (
  input  logic [7:0] data,
  input  logic       inv,
  output logic [7:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = v;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] pre;
  logic [7:0] post;

  // Affine transform after inversion (forward) or its inverse before inversion.
  always_comb begin
    pre    = {data[6:0], data[7]} ^ {data[4:0], data[7:5]} ^ {data[1:0], data[7:2]} ^ 8'h05;
    post   = gf_inv(data);
    result = post ^ {post[6:0], post[7]} ^ {post[5:0], post[7:6]}
                  ^ {post[4:0], post[7:5]} ^ {post[3:0], post[7:4]} ^ 8'h63;
    if (inv) result = gf_inv(pre);
  end

endmodule

module aes_v3_word #(
  parameter int unsigned SBOXES      = 1,
  parameter int unsigned GATE_OUTPUT = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic        mix,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy
);

  localparam int unsigned GROUPS = 4 / SBOXES;
  localparam int unsigned GW     = 8 * SBOXES;
  localparam logic [1:0]  LAST   = 2'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] res_q, res_d;
  logic [31:0] rd_q, rd_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [GW-1:0] grp;
  logic [7:0]    sb_in  [SBOXES];
  logic [7:0]    sb_out [SBOXES];
  logic [31:0]   sub_word;

  // One output byte of (Inv)MixColumns from b_i, b_(i+1), b_(i+2), b_(i+3).
  function automatic logic [7:0] col_byte(input logic [7:0] p, input logic [7:0] q,
                                          input logic [7:0] r, input logic [7:0] s,
                                          input logic inv);
    logic [7:0] p2, p4, p8, q2, q4, q8, r2, r4, r8, s2, s4, s8;
    p2 = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    q2 = {q[6:0], 1'b0} ^ (q[7] ? 8'h1b : 8'h00);
    r2 = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    s2 = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    p4 = {p2[6:0], 1'b0} ^ (p2[7] ? 8'h1b : 8'h00);
    q4 = {q2[6:0], 1'b0} ^ (q2[7] ? 8'h1b : 8'h00);
    r4 = {r2[6:0], 1'b0} ^ (r2[7] ? 8'h1b : 8'h00);
    s4 = {s2[6:0], 1'b0} ^ (s2[7] ? 8'h1b : 8'h00);
    p8 = {p4[6:0], 1'b0} ^ (p4[7] ? 8'h1b : 8'h00);
    q8 = {q4[6:0], 1'b0} ^ (q4[7] ? 8'h1b : 8'h00);
    r8 = {r4[6:0], 1'b0} ^ (r4[7] ? 8'h1b : 8'h00);
    s8 = {s4[6:0], 1'b0} ^ (s4[7] ? 8'h1b : 8'h00);
    if (inv) return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (r8 ^ r4 ^ r) ^ (s8 ^ s);
    return p2 ^ (q2 ^ q) ^ r ^ s;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[7:0];
    b1 = w[15:8];
    b2 = w[23:16];
    b3 = w[31:24];
    return {col_byte(b3, b0, b1, b2, inv), col_byte(b2, b3, b0, b1, inv),
            col_byte(b1, b2, b3, b0, inv), col_byte(b0, b1, b2, b3, inv)};
  endfunction

  // Current byte group of the registered source column.
  assign grp = GW'(rs1_q >> (32'(cnt_q) * GW));

  for (genvar g = 0; g < SBOXES; g++) begin : g_sbox
    // Inputs held at zero outside SUB so the S-boxes do not toggle while idle.
    assign sb_in[g] = (state_q == SUB) ? grp[8*g +: 8] : 8'h00;
    aes_sbox u_sbox (
      .data   (sb_in[g]),
      .inv    (dec_q),
      .result (sb_out[g])
    );
  end

  // Result word with the current group's bytes replaced by S-box outputs.
  for (genvar k = 0; k < 4; k++) begin : g_merge
    assign sub_word[8*k +: 8] = (cnt_q == 2'(k / SBOXES)) ? sb_out[k % SBOXES]
                                                          : res_q[8*k +: 8];
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; a dropped valid in SUB aborts the operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = mix ? DONE : SUB;
      SUB: begin
        if (!valid)              state_d = IDLE;
        else if (cnt_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d = cnt_q;
    dec_d = dec_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          dec_d = dec;
          rs1_d = rs1;
          rs2_d = rs2;
          cnt_d = 2'd0;
          res_d = mix ? mix_col(rs1, dec) : 32'h0;
        end
      end
      SUB: begin
        if (!valid) begin
          cnt_d = 2'd0;
          res_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 2'd1;
          res_d = sub_word;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    if (state_d == DONE)       rd_d = res_d ^ rs2_d;
    else if (GATE_OUTPUT != 0) rd_d = 32'h0;
    else                       rd_d = rd_q;
  end

  // Datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_q   <= 2'd0;
      dec_q   <= 1'b0;
      rs1_q   <= 32'h0;
      rs2_q   <= 32'h0;
      res_q   <= 32'h0;
      rd_q    <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_aes_v3_word.sv
// Bench for aes_v3_word: three instances (SBOXES=1/2 gated, SBOXES=4 ungated)
// share operands and clock/reset; each has its own valid. Results are compared
// against an AES model built from log/antilog tables of GF(2^8).
module tb_aes_v3_word;

  logic        clk;
  logic        rst_n;
  logic        dec;
  logic        mix;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        vld   [3];
  logic [31:0] rd_o  [3];
  logic        rdy   [3];
  logic        bsy   [3];

  int checks;
  int errors;

  int         exp_t [256];
  int         log_t [256];
  logic [7:0] sbf   [256];
  logic [7:0] sbi   [256];

  aes_v3_word #(.SBOXES(1), .GATE_OUTPUT(1)) u_d1 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[0]), .dec(dec), .mix(mix),
    .rs1(rs1), .rs2(rs2), .rd(rd_o[0]), .ready(rdy[0]), .busy(bsy[0]));
  aes_v3_word #(.SBOXES(2), .GATE_OUTPUT(1)) u_d2 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[1]), .dec(dec), .mix(mix),
    .rs1(rs1), .rs2(rs2), .rd(rd_o[1]), .ready(rdy[1]), .busy(bsy[1]));
  aes_v3_word #(.SBOXES(4), .GATE_OUTPUT(0)) u_d4 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[2]), .dec(dec), .mix(mix),
    .rs1(rs1), .rs2(rs2), .rd(rd_o[2]), .ready(rdy[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void build_tables();
    int e, iv, s;
    e = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ (((e << 1) ^ (((e & 'h80) != 0) ? 'h1b : 0)) & 'hff);
    end
    exp_t[255] = 1;
    log_t[0] = 0;
    for (int x = 0; x < 256; x++) begin
      iv = (x == 0) ? 0 : exp_t[(255 - log_t[x]) % 255];
      s = 0;
      for (int b = 0; b < 8; b++) begin
        int bit_v;
        bit_v = ((iv >> b) ^ (iv >> ((b + 4) % 8)) ^ (iv >> ((b + 5) % 8))
                ^ (iv >> ((b + 6) % 8)) ^ (iv >> ((b + 7) % 8)) ^ ('h63 >> b)) & 1;
        s = s | (bit_v << b);
      end
      sbf[x] = 8'(s);
      sbi[s] = 8'(x);
    end
  endfunction

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [31:0] model(bit dc, bit mx, logic [31:0] a, logic [31:0] k);
    int by [4];
    int cf [4];
    logic [31:0] o;
    o = 32'h0;
    for (int i = 0; i < 4; i++) by[i] = int'((a >> (8 * i)) & 32'hff);
    if (dc) begin cf[0] = 14; cf[1] = 11; cf[2] = 13; cf[3] = 9; end
    else    begin cf[0] = 2;  cf[1] = 3;  cf[2] = 1;  cf[3] = 1; end
    for (int i = 0; i < 4; i++) begin
      int v;
      if (mx) begin
        v = 0;
        for (int j = 0; j < 4; j++) v = v ^ gmul(cf[j], by[(i + j) % 4]);
      end else begin
        v = dc ? int'(sbi[by[i]]) : int'(sbf[by[i]]);
      end
      o = o | (32'(v) << (8 * i));
    end
    return o ^ k;
  endfunction

  function automatic int lat_of(int d, bit mx);
    int sb;
    sb = (d == 0) ? 1 : (d == 1) ? 2 : 4;
    return mx ? 1 : 4 / sb + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just before the acceptance edge with valid high; returns in the ready cycle.
  task automatic wait_done(input int d, input int lat, input logic [31:0] exp, input bit scr);
    int n;
    @(posedge clk);
    n = 1;
    #1;
    while (!rdy[d] && n < 20) begin
      if (d != 2) check("rd_gated_busy", rd_o[d], 32'h0);
      if (scr) begin
        rs1 = $urandom;
        rs2 = $urandom;
        dec = 1'($urandom);
        mix = 1'($urandom);
      end
      @(posedge clk);
      n++;
      #1;
    end
    check("latency", 32'(n), 32'(lat));
    check("rd", rd_o[d], exp);
    check("busy_done", 32'(bsy[d]), 32'h1);
  endtask

  task automatic run_op(input int d, input bit dc, input bit mx, input logic [31:0] a,
                        input logic [31:0] k, input logic [31:0] exp, input bit scr);
    @(negedge clk);
    dec = dc; mix = mx; rs1 = a; rs2 = k;
    vld[d] = 1'b1;
    wait_done(d, lat_of(d, mx), exp, scr);
    vld[d] = 1'b0;
    @(posedge clk);
    #1;
    check("ready_pulse", 32'(rdy[d]), 32'h0);
    check("busy_idle", 32'(bsy[d]), 32'h0);
    check("rd_after", rd_o[d], (d == 2) ? exp : 32'h0);
  endtask

  initial begin
    int pulses;
    bit dc, mx;
    logic [31:0] a, k, e;
    checks = 0;
    errors = 0;
    build_tables();
    rst_n = 1'b0;
    dec = 1'b0; mix = 1'b0; rs1 = 32'h0; rs2 = 32'h0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 32'(rdy[i]), 32'h0);
      check("rst_busy", 32'(bsy[i]), 32'h0);
      check("rst_rd", rd_o[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(0, 1'b0, 1'b0, 32'h53010000, 32'h0, 32'hED7C6363, 1'b0);
    for (int d = 0; d < 3; d++)
      run_op(d, 1'b1, 1'b0, 32'h63636363, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(0, 1'b0, 1'b1, 32'h455313DB, 32'h0, 32'hBCA14D8E, 1'b0);
    run_op(0, 1'b1, 1'b1, 32'hBCA14D8E, 32'h0, 32'h455313DB, 1'b0);
    run_op(2, 1'b0, 1'b1, 32'h455313DB, 32'h12345678, 32'hBCA14D8E ^ 32'h12345678, 1'b0);

    // Abort: drop valid in the second SUB cycle.
    @(negedge clk);
    dec = 1'b0; mix = 1'b0; rs1 = 32'hA5A5A5A5; rs2 = 32'h0;
    vld[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    check("abort_busy_hold", 32'(bsy[0]), 32'h1);
    pulses = 0;
    @(posedge clk);
    #1;
    check("abort_busy_fall", 32'(bsy[0]), 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (rdy[0]) pulses++;
      @(posedge clk);
      #1;
    end
    check("abort_no_ready", 32'(pulses), 32'h0);
    run_op(0, 1'b0, 1'b0, 32'h00102030, 32'hCAFEF00D,
           model(1'b0, 1'b0, 32'h00102030, 32'hCAFEF00D), 1'b0);

    // Randomized operations, alternating operand scrambling while busy.
    for (int r = 0; r < 15; r++) begin
      dc = 1'($urandom);
      mx = 1'($urandom);
      a  = $urandom;
      k  = $urandom;
      run_op(r % 3, dc, mx, a, k, model(dc, mx, a, k), 1'(r % 2));
    end

    // Asynchronous reset in the middle of SUB.
    @(negedge clk);
    dec = 1'b1; mix = 1'b0; rs1 = $urandom; rs2 = $urandom;
    vld[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_rst_ready", 32'(rdy[0]), 32'h0);
    check("amid_rst_busy", 32'(bsy[0]), 32'h0);
    check("amid_rst_rd", rd_o[0], 32'h0);
    check("amid_rst_rd_ungated", rd_o[2], 32'h0);
    @(negedge clk);
    vld[0] = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (rdy[0]) pulses++;
    end
    check("post_rst_no_ready", 32'(pulses), 32'h0);

    // Back-to-back pair: SubWord then MixColumns, valid kept high throughout.
    @(negedge clk);
    dc = 1'($urandom); a = $urandom; k = $urandom;
    dec = dc; mix = 1'b0; rs1 = a; rs2 = k;
    vld[0] = 1'b1;
    wait_done(0, 5, model(dc, 1'b0, a, k), 1'b0);
    dc = 1'($urandom); a = $urandom; k = $urandom;
    dec = dc; mix = 1'b1; rs1 = a; rs2 = k;
    @(posedge clk);
    #1;
    check("b2b_single_pulse", 32'(rdy[0]), 32'h0);
    check("b2b_idle_busy", 32'(bsy[0]), 32'h0);
    wait_done(0, 1, model(dc, 1'b1, a, k), 1'b0);
    vld[0] = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_end_pulse", 32'(rdy[0]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
